// File: rtl/spi_xip_pkg.sv
// Shared types and frame geometry for the SPI execute-in-place reader.
// Field widths are fixed; only the opcode and address contents vary.
package spi_xip_pkg;

    localparam int CMD_W   = 8;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;
    localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        RESP
    } state_t;

    function automatic int div_cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/spi_xip_shifter.sv
// SPI mode-0 shift engine: one frame per start, MSB first.
// Samples MISO on SCK rise, updates MOSI on SCK fall.
module spi_xip_shifter
    import spi_xip_pkg::*;
#(
    parameter int SCK_DIV = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    input  logic               start,
    input  logic               miso,
    output logic               sck,
    output logic               mosi,
    output logic [DATA_W-1:0]  rx_word,
    output logic               done
);

    localparam int CW = div_cnt_w(SCK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(SCK_DIV - 1);
    localparam int BW = $clog2(FRAME_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);

    logic               active;
    logic               phase_lo;
    logic [CW-1:0]      div_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [FRAME_W-1:0] tx_sr;
    logic               half_end;

    assign half_end = active && (div_cnt == DIV_LAST);
    assign done     = half_end && phase_lo && (bit_cnt == BIT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active   <= 1'b0;
            phase_lo <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_word  <= '0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            if (load) begin
                tx_sr <= frame;
                mosi  <= frame[FRAME_W-1];
            end
            if (start) begin
                active   <= 1'b1;
                phase_lo <= 1'b0;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                sck      <= 1'b1;
                rx_word  <= {rx_word[DATA_W-2:0], miso};
            end else if (active) begin
                if (!half_end) begin
                    div_cnt <= div_cnt + 1'b1;
                end else begin
                    div_cnt <= '0;
                    if (!phase_lo) begin
                        sck      <= 1'b0;
                        phase_lo <= 1'b1;
                        tx_sr    <= {tx_sr[FRAME_W-2:0], 1'b0};
                        mosi     <= tx_sr[FRAME_W-2];
                    end else if (bit_cnt == BIT_LAST) begin
                        // last low half done: no further rising edge
                        active <= 1'b0;
                    end else begin
                        sck      <= 1'b1;
                        phase_lo <= 1'b0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        rx_word  <= {rx_word[DATA_W-2:0], miso};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_xip_apb.sv
// APB-slave XIP flash reader with a one-entry read buffer.
// Writes and out-of-window reads get an immediate error.
module spi_xip_apb
    import spi_xip_pkg::*;
#(
    parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
    parameter int          ADDR_BITS  = 24,
    parameter logic [7:0]  CMD_OP     = 8'h03,
    parameter int          SCK_DIV    = 1,
    parameter int          SS_NUM     = 8,
    parameter int          SS_IDX     = 0,
    parameter int          SWAP_BYTES = 1,
    parameter int          BUF_EN     = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       in_paddr,
    input  logic              in_psel,
    input  logic              in_penable,
    input  logic [2:0]        in_pprot,
    input  logic              in_pwrite,
    input  logic [31:0]       in_pwdata,
    input  logic [3:0]        in_pstrb,
    output logic              in_pready,
    output logic [31:0]       in_prdata,
    output logic              in_pslverr,
    input  logic              flush,
    output logic              spi_sck,
    output logic [SS_NUM-1:0] spi_ss,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              busy
);

    localparam int TAG_W = ADDR_BITS - 2;
    localparam int CW = div_cnt_w(SCK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(SCK_DIV - 1);
    localparam logic [31:0] WIN_MASK = (32'h1 << ADDR_BITS) - 32'h1;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [TAG_W-1:0]   tag_q;
    logic [TAG_W-1:0]   buf_tag;
    logic [31:0]        buf_data;
    logic               buf_vld;
    logic               flush_seen;
    logic               dropped;

    logic               access;
    logic               in_win;
    logic               hit;
    logic               err_resp;
    logic               hit_resp;
    logic               miss;
    logic               start;
    logic               sh_done;
    logic               resp_out;
    logic [ADDR_W-1:0]  addr_ext;
    logic [FRAME_W-1:0] frame;
    logic [DATA_W-1:0]  rx_word;
    logic [31:0]        word;
    logic               unused_ok;

    assign unused_ok = ^{in_pprot, in_pwdata, in_pstrb};

    always_comb begin
        access   = (state == IDLE) && in_psel && in_penable;
        in_win   = (in_paddr & ~WIN_MASK) == FLASH_BASE;
        hit      = (BUF_EN != 0) && buf_vld
                   && (buf_tag == in_paddr[ADDR_BITS-1:2]);
        err_resp = access && (in_pwrite || !in_win);
        hit_resp = access && !in_pwrite && in_win && hit;
        miss     = access && !in_pwrite && in_win && !hit;
        addr_ext = '0;
        addr_ext[ADDR_BITS-1:0] = {in_paddr[ADDR_BITS-1:2], 2'b00};
        frame    = {CMD_OP, addr_ext, {DATA_W{1'b0}}};
        // rx_word holds the first received byte in its top lane
        word     = (SWAP_BYTES != 0)
                   ? {rx_word[7:0], rx_word[15:8],
                      rx_word[23:16], rx_word[31:24]}
                   : rx_word;
        start    = (state == SETUP) && (cnt == DIV_LAST);
        resp_out = (state == RESP) && !dropped;
    end

    assign in_pready  = err_resp | hit_resp | resp_out;
    assign in_pslverr = err_resp;
    assign in_prdata  = hit_resp ? buf_data
                      : resp_out ? word : 32'h0;
    assign busy       = (state != IDLE);

    spi_xip_shifter #(
        .SCK_DIV (SCK_DIV)
    ) u_shifter (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (miss),
        .frame   (frame),
        .start   (start),
        .miso    (spi_miso),
        .sck     (spi_sck),
        .mosi    (spi_mosi),
        .rx_word (rx_word),
        .done    (sh_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            spi_ss     <= '1;
            tag_q      <= '0;
            buf_tag    <= '0;
            buf_data   <= '0;
            buf_vld    <= 1'b0;
            flush_seen <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            if (flush && state == IDLE)
                buf_vld <= 1'b0;
            if (flush && state != IDLE)
                flush_seen <= 1'b1;
            if (!in_psel && state inside {SETUP, SHIFT, HOLD})
                dropped <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (miss) begin
                        state          <= SETUP;
                        cnt            <= '0;
                        tag_q          <= in_paddr[ADDR_BITS-1:2];
                        spi_ss[SS_IDX] <= 1'b0;
                        flush_seen     <= 1'b0;
                        dropped        <= 1'b0;
                    end
                end
                SETUP: begin
                    cnt <= cnt + 1'b1;
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (sh_done) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (cnt == DIV_LAST) begin
                        state  <= RESP;
                        spi_ss <= '1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (!(flush_seen || flush)) begin
                        buf_vld  <= 1'b1;
                        buf_tag  <= tag_q;
                        buf_data <= word;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xip_apb.sv
// Directed bench for spi_xip_apb: two instances (fast/swap, slow/no-swap)
// each with a behavioural mode-0 SPI flash model.
module tb_spi_xip_apb;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] paddr;
    logic        penable;
    logic        pwrite;
    logic        flush;
    logic        psel    [2];
    logic        sck     [2];
    logic        mosi    [2];
    logic        miso    [2];
    logic        pready  [2];
    logic        pslverr [2];
    logic        busy    [2];
    logic [31:0] prdata  [2];
    logic [7:0]  ss      [2];

    int          nvec = 0;
    int          nerr = 0;
    int          fcnt [2];
    logic [31:0] fsr  [2];
    time         tr   [2][2];
    int          nsck [2];
    int          sslo [2];

    always #5 clock = ~clock;

    spi_xip_apb u_dut_a (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_paddr   (paddr),
        .in_psel    (psel[0]),
        .in_penable (penable),
        .in_pprot   (3'b000),
        .in_pwrite  (pwrite),
        .in_pwdata  (32'h0),
        .in_pstrb   (4'hF),
        .in_pready  (pready[0]),
        .in_prdata  (prdata[0]),
        .in_pslverr (pslverr[0]),
        .flush      (flush),
        .spi_sck    (sck[0]),
        .spi_ss     (ss[0]),
        .spi_mosi   (mosi[0]),
        .spi_miso   (miso[0]),
        .busy       (busy[0])
    );

    spi_xip_apb #(
        .SCK_DIV    (3),
        .SWAP_BYTES (0)
    ) u_dut_b (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_paddr   (paddr),
        .in_psel    (psel[1]),
        .in_penable (penable),
        .in_pprot   (3'b000),
        .in_pwrite  (pwrite),
        .in_pwdata  (32'h0),
        .in_pstrb   (4'hF),
        .in_pready  (pready[1]),
        .in_prdata  (prdata[1]),
        .in_pslverr (pslverr[1]),
        .flush      (flush),
        .spi_sck    (sck[1]),
        .spi_ss     (ss[1]),
        .spi_mosi   (mosi[1]),
        .spi_miso   (miso[1]),
        .busy       (busy[1])
    );

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            24'hFFFFFC: return 8'hA1;
            24'hFFFFFD: return 8'hB2;
            24'hFFFFFE: return 8'hC3;
            24'hFFFFFF: return 8'hD4;
            default:    return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_flash
        initial begin
            int         idx;
            logic [7:0] b;
            miso[g] = 1'b0;
            fcnt[g] = 0;
            fsr[g]  = 32'h0;
            forever begin
                @(negedge ss[g][0]);
                fcnt[g] = 0;
                fsr[g]  = 32'h0;
                miso[g] = 1'b0;
                while (ss[g][0] == 1'b0) begin
                    @(sck[g] or ss[g][0]);
                    if (ss[g][0] !== 1'b0)
                        break;
                    if (sck[g]) begin
                        if (fcnt[g] < 2)
                            tr[g][fcnt[g]] = $time;
                        if (fcnt[g] < 32)
                            fsr[g] = {fsr[g][30:0], mosi[g]};
                        fcnt[g]++;
                    end else if (fcnt[g] >= 32 && fcnt[g] < 64) begin
                        idx = fcnt[g] - 32;
                        b = fbyte(fsr[g][23:0] + 24'(idx / 8));
                        miso[g] = b[7 - (idx % 8)];
                    end
                end
            end
        end

        always @(posedge sck[g]) nsck[g]++;

        always @(negedge clock)
            if (ss[g][0] === 1'b0) sslo[g]++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input int d, input logic wr,
                            input logic [31:0] a,
                            output logic [31:0] rd,
                            output logic err, output int lat);
        @(posedge clock); #1;
        paddr   = a;
        pwrite  = wr;
        psel[d] = 1'b1;
        penable = 1'b0;
        @(posedge clock); #1;
        penable = 1'b1;
        lat = 0;
        forever begin
            @(negedge clock);
            if (pready[d]) break;
            if (lat >= 1000) begin
                check("timeout", 32'(pready[d]), 32'd1);
                break;
            end
            @(posedge clock); #1;
            lat++;
        end
        rd  = prdata[d];
        err = pslverr[d];
        @(posedge clock); #1;
        psel[d] = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          e0;
        int          s0;
        int          n;
        paddr   = 32'h0;
        penable = 1'b0;
        pwrite  = 1'b0;
        flush   = 1'b0;
        psel[0] = 1'b0;
        psel[1] = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ss",     32'(ss[0]),      32'hFF);
        check("rst_sck",    32'(sck[0]),     32'd0);
        check("rst_mosi",   32'(mosi[0]),    32'd0);
        check("rst_pready", 32'(pready[0]),  32'd0);
        check("rst_prdata", prdata[0],       32'h0);
        check("rst_slverr", 32'(pslverr[0]), 32'd0);
        check("rst_busy",   32'(busy[0]),    32'd0);
        reset_n = 1'b1;

        e0 = nsck[0];
        s0 = sslo[0];
        apb_xfer(0, 1'b0, 32'h3000_0100, rd, err, lat);
        check("miss_lat",    32'(lat),          32'd131);
        check("miss_data",   rd,                32'h4433_2211);
        check("miss_err",    32'(err),          32'd0);
        check("miss_cmd",    fsr[0],            32'h0300_0100);
        check("miss_ss_low", 32'(sslo[0] - s0), 32'd130);
        check("miss_sck",    32'(nsck[0] - e0), 32'd64);

        e0 = nsck[0];
        apb_xfer(0, 1'b0, 32'h3000_0100, rd, err, lat);
        check("hit_lat",  32'(lat),          32'd0);
        check("hit_data", rd,                32'h4433_2211);
        check("hit_err",  32'(err),          32'd0);
        check("hit_sck",  32'(nsck[0] - e0), 32'd0);

        @(posedge clock); #1 flush = 1'b1;
        @(posedge clock); #1 flush = 1'b0;
        apb_xfer(0, 1'b0, 32'h3000_0100, rd, err, lat);
        check("flush_lat",  32'(lat), 32'd131);
        check("flush_data", rd,       32'h4433_2211);

        s0 = sslo[0];
        apb_xfer(0, 1'b1, 32'h3000_0000, rd, err, lat);
        check("wr_lat", 32'(lat), 32'd0);
        check("wr_err", 32'(err), 32'd1);
        apb_xfer(0, 1'b0, 32'h4000_0000, rd, err, lat);
        check("oow_lat",  32'(lat),          32'd0);
        check("oow_err",  32'(err),          32'd1);
        check("err_ssl",  32'(sslo[0] - s0), 32'd0);
        check("err_ss",   32'(ss[0]),        32'hFF);

        s0 = sslo[1];
        apb_xfer(1, 1'b0, 32'h30FF_FFFC, rd, err, lat);
        check("div3_cmd",   fsr[1],                   32'h03FF_FFFC);
        check("div3_lat",   32'(lat),                 32'd391);
        check("div3_data",  rd,                       32'hA1B2_C3D4);
        check("div3_per",   32'(tr[1][1] - tr[1][0]), 32'd60);
        check("div3_ssl",   32'(sslo[1] - s0),        32'd390);

        fork
            apb_xfer(0, 1'b0, 32'h3000_0200, rd, err, lat);
            begin
                repeat (50) @(posedge clock);
                #1 flush = 1'b1;
                @(posedge clock);
                #1 flush = 1'b0;
            end
        join
        check("mflush_lat",  32'(lat), 32'd131);
        check("mflush_data", rd,       32'h5958_5B5A);
        apb_xfer(0, 1'b0, 32'h3000_0200, rd, err, lat);
        check("mflush_relat", 32'(lat), 32'd131);
        check("mflush_redat", rd,       32'h5958_5B5A);

        @(posedge clock); #1;
        paddr   = 32'h3000_0100;
        pwrite  = 1'b0;
        psel[0] = 1'b1;
        penable = 1'b0;
        @(posedge clock); #1;
        penable = 1'b1;
        n = 0;
        while (fcnt[0] != 20 && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500)
            check("rst_reach", 32'(fcnt[0]), 32'd20);
        check("mid_busy", 32'(busy[0]), 32'd1);
        check("mid_sck",  32'(sck[0]),  32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_ss",     32'(ss[0]),     32'hFF);
        check("arst_sck",    32'(sck[0]),    32'd0);
        check("arst_pready", 32'(pready[0]), 32'd0);
        check("arst_busy",   32'(busy[0]),   32'd0);
        psel[0] = 1'b0;
        penable = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        apb_xfer(0, 1'b0, 32'h3000_0200, rd, err, lat);
        check("post_rst_lat",  32'(lat), 32'd131);
        check("post_rst_data", rd,       32'h5958_5B5A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
